// File: rtl/not_bubble_pkg.sv
// not_bubble_pkg: shared types, constants and helpers for not_bubble_pipe.
//   inv_mask_t   : per-operand inversion mask {inv_out, inv_d, inv_c, inv_b, inv_a}
//   INV_MASK_RST : reset mask, reproduces y = ~((~a & ~b) | (c & d))
//   apply_inv    : XOR a vector with a replicated inversion bit
package not_bubble_pkg;

    typedef struct packed {
        logic inv_out;
        logic inv_d;
        logic inv_c;
        logic inv_b;
        logic inv_a;
    } inv_mask_t;

    localparam inv_mask_t INV_MASK_RST = 5'b10011;

    // Widest operand apply_inv can handle; callers zero-extend and keep the low lanes.
    localparam int unsigned VEC_MAX_W = 64;

    function automatic logic [VEC_MAX_W-1:0] apply_inv(input logic [VEC_MAX_W-1:0] vec,
                                                       input logic                 inv);
        return vec ^ {VEC_MAX_W{inv}};
    endfunction

endpackage

// File: rtl/not_bubble_stage.sv
// not_bubble_stage: one valid/ready pipeline register, no skid buffer.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload (held while stalled)
// The stage accepts whenever it is empty or its content leaves this cycle, so in_ready
// is combinational on out_ready.
module not_bubble_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/not_bubble_pipe.sv
// not_bubble_pipe: two-stage pipelined inverter-bubble logic tree.
//   y = inv_out ^ (((a^inv_a) & (b^inv_b)) | ((c^inv_c) & (d^inv_d))) per lane.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_we, cfg_mask     : load the inversion mask {inv_out, inv_d, inv_c, inv_b, inv_a}
//   mask_q               : active mask
//   in_valid/in_ready    : input handshake for operands a, b, c, d
//   out_valid/out_ready  : output handshake for result y
//   out_count            : count of transferred output beats (wraps)
// Optional (macro NOT_BUBBLE_PIPE_PARITY_EN):
//   y_par                : XOR-reduce of y, registered with y
//   par_err              : sticky parity mismatch between S1 and S2, cleared by reset
// WIDTH must be below not_bubble_pkg::VEC_MAX_W.
module not_bubble_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [4:0]       cfg_mask,
    output logic [4:0]       mask_q,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] out_count
`ifdef NOT_BUBBLE_PIPE_PARITY_EN
    ,
    output logic             y_par,
    output logic             par_err
`endif
);

    import not_bubble_pkg::*;

`ifdef NOT_BUBBLE_PIPE_PARITY_EN
    localparam int unsigned S1_W = 2 * WIDTH + 2;
    localparam int unsigned S2_W = WIDTH + 1;
`else
    localparam int unsigned S1_W = 2 * WIDTH + 1;
    localparam int unsigned S2_W = WIDTH;
`endif

    // ---------------- Mask register ----------------
    logic [4:0] mask_d;
    inv_mask_t  mask_cur;

    assign mask_cur = inv_mask_t'(mask_q);

    always_comb begin
        mask_d = mask_q;
        if (cfg_we) begin
            mask_d = cfg_mask;
        end
    end

    // The mask sampled by S1 is the pre-edge value, so a beat accepted together with
    // cfg_we still uses the old mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= INV_MASK_RST;
        end else begin
            mask_q <= mask_d;
        end
    end

    // ---------------- Operand conditioning ----------------
    logic [VEC_MAX_W-1:0] a_x, b_x, c_x, d_x;
    logic [WIDTH-1:0]     and1, and2;
    logic                 unused_hi;

    assign a_x  = apply_inv(VEC_MAX_W'(a), mask_cur.inv_a);
    assign b_x  = apply_inv(VEC_MAX_W'(b), mask_cur.inv_b);
    assign c_x  = apply_inv(VEC_MAX_W'(c), mask_cur.inv_c);
    assign d_x  = apply_inv(VEC_MAX_W'(d), mask_cur.inv_d);
    assign and1 = a_x[WIDTH-1:0] & b_x[WIDTH-1:0];
    assign and2 = c_x[WIDTH-1:0] & d_x[WIDTH-1:0];

    assign unused_hi = ^{a_x[VEC_MAX_W-1:WIDTH], b_x[VEC_MAX_W-1:WIDTH],
                         c_x[VEC_MAX_W-1:WIDTH], d_x[VEC_MAX_W-1:WIDTH]};

    // ---------------- Stage 1 ----------------
    logic [S1_W-1:0]  s1_in, s1_out;
    logic             s1_valid, s2_in_ready;
    logic [WIDTH-1:0] s1_and1, s1_and2, s1_or;
    logic             s1_inv_out;

`ifdef NOT_BUBBLE_PIPE_PARITY_EN
    assign s1_in = {^(and1 | and2), mask_cur.inv_out, and2, and1};
`else
    assign s1_in = {mask_cur.inv_out, and2, and1};
`endif

    not_bubble_stage #(
        .WIDTH(S1_W)
    ) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s1_in),
        .out_valid(s1_valid),
        .out_ready(s2_in_ready),
        .out_data (s1_out)
    );

    assign s1_and1    = s1_out[WIDTH-1:0];
    assign s1_and2    = s1_out[2*WIDTH-1:WIDTH];
    assign s1_inv_out = s1_out[2*WIDTH];
    assign s1_or      = s1_and1 | s1_and2;

    // ---------------- Stage 2 ----------------
    logic [WIDTH-1:0] y_next;
    logic [S2_W-1:0]  s2_in, s2_out;

    assign y_next = {WIDTH{s1_inv_out}} ^ s1_or;

`ifdef NOT_BUBBLE_PIPE_PARITY_EN
    assign s2_in = {^y_next, y_next};
`else
    assign s2_in = y_next;
`endif

    not_bubble_stage #(
        .WIDTH(S2_W)
    ) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid),
        .in_ready (s2_in_ready),
        .in_data  (s2_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (s2_out)
    );

    assign y = s2_out[WIDTH-1:0];

`ifdef NOT_BUBBLE_PIPE_PARITY_EN
    logic par_err_q, par_err_d;
    logic par_mis;

    assign y_par   = s2_out[WIDTH];
    assign par_err = par_err_q;
    // Parity carried from S1 entry is rechecked as the beat moves into S2.
    assign par_mis = s1_out[2*WIDTH+1] ^ (^s1_or);

    always_comb begin
        par_err_d = par_err_q;
        if (s1_valid && s2_in_ready && par_mis) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    // ---------------- Output beat counter ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign out_count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_not_bubble_pipe.sv
// tb_not_bubble_pipe: directed, scoreboard-based bench for not_bubble_pipe (WIDTH=8).
// A small valid-bit model of the two stages predicts in_ready/out_valid; expected results
// are queued at accept time and compared whenever S2 is predicted valid.
// Parity outputs are checked when NOT_BUBBLE_PIPE_PARITY_EN is defined.
module tb_not_bubble_pipe;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_mask;
    logic [4:0]  mask_q;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b, c, d;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic [15:0] out_count;
`ifdef NOT_BUBBLE_PIPE_PARITY_EN
    logic        y_par;
    logic        par_err;
`endif

    not_bubble_pipe #(
        .WIDTH(8),
        .CNT_W(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_mask (cfg_mask),
        .mask_q   (mask_q),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .out_count(out_count)
`ifdef NOT_BUBBLE_PIPE_PARITY_EN
        ,
        .y_par    (y_par),
        .par_err  (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    logic [4:0]  mdl_mask;
    logic [15:0] mdl_cnt;
    logic        mdl_s1v, mdl_s2v;
    logic        last_acc;

    function automatic logic [7:0] model(input logic [4:0] m, input logic [7:0] av,
                                         input logic [7:0] bv, input logic [7:0] cv,
                                         input logic [7:0] dv);
        logic [7:0] t1, t2;
        t1 = (av ^ {8{m[0]}}) & (bv ^ {8{m[1]}});
        t2 = (cv ^ {8{m[2]}}) & (dv ^ {8{m[3]}});
        return {8{m[4]}} ^ (t1 | t2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at the negedge, check #1 later, advance the model at the posedge.
    task automatic step(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] cv, input logic [7:0] dv, input logic ordy,
                        input logic we, input logic [4:0] cm);
        logic       s2_free, s1_free, xfer;
        logic [7:0] e;
        in_valid  = iv;
        a         = av;
        b         = bv;
        c         = cv;
        d         = dv;
        out_ready = ordy;
        cfg_we    = we;
        cfg_mask  = cm;
        #1;
        s2_free = !mdl_s2v || ordy;
        s1_free = !mdl_s1v || s2_free;
        chk("in_ready", in_ready, s1_free);
        chk("out_valid", out_valid, mdl_s2v);
        chk("mask_q", mask_q, mdl_mask);
        chk("out_count", out_count, mdl_cnt);
        last_acc = iv && s1_free;
        xfer     = mdl_s2v && ordy;
        if (mdl_s2v) begin
            e = exp_q[0];
            chk("y", y, e);
`ifdef NOT_BUBBLE_PIPE_PARITY_EN
            chk("y_par", y_par, ^e);
`endif
        end
        if (xfer) exp_q.delete(0);
        if (last_acc) exp_q.push_back(model(mdl_mask, av, bv, cv, dv));
        @(posedge clk);
        if (xfer) mdl_cnt++;
        mdl_s2v = s2_free ? mdl_s1v : mdl_s2v;
        mdl_s1v = s1_free ? iv : mdl_s1v;
        if (we) mdl_mask = cm;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, ordy, 1'b0, 5'h00);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_mask", mask_q, 5'h13);
        chk("rst_y", y, 0);
`ifdef NOT_BUBBLE_PIPE_PARITY_EN
        chk("rst_y_par", y_par, 0);
        chk("rst_par_err", par_err, 0);
`endif
        exp_q.delete();
        mdl_s1v  = 1'b0;
        mdl_s2v  = 1'b0;
        mdl_cnt  = '0;
        mdl_mask = 5'h13;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] sa[10], sb[10], sc[10], sd[10];
    logic [7:0] ta[3], tb[3], tc[3], td[3];

    initial begin
        int i;
        int idx;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        cfg_mask  = 5'h00;
        out_ready = 1'b0;
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
        mdl_s1v = 1'b0; mdl_s2v = 1'b0; mdl_cnt = '0; mdl_mask = 5'h13; last_acc = 1'b0;
        #2;
        do_reset();

        // Reset mask, result visible two cycles after the accept cycle.
        step(1'b1, 8'hF0, 8'h0F, 8'hFF, 8'h3C, 1'b1, 1'b0, 5'h00);
        chk("t1_accept", last_acc, 1);
        idle(1'b1);
        chk("t1_lat_valid", out_valid, 1);
        chk("t1_y", y, 8'hC3);
        idle(1'b1);

        // All-zero operands.
        step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 5'h00);
        idle(1'b1);
        chk("t2_y", y, 8'h00);
        idle(1'b1);

        // Mask write coincident with an accept: that beat keeps the old mask.
        step(1'b1, 8'hF0, 8'h0F, 8'hFF, 8'h3C, 1'b1, 1'b1, 5'h00);
        step(1'b1, 8'hF0, 8'h3C, 8'h0F, 8'h05, 1'b1, 1'b0, 5'h00);
        chk("t3_y_oldmask", y, 8'hC3);
        chk("t3_mask", mask_q, 5'h00);
        idle(1'b1);
        chk("t3_y_newmask", y, 8'h35);
        idle(1'b1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 5'h13);

        // Backpressure: three beats offered, two fit.
        do_reset();
        ta[0] = 8'hF0; tb[0] = 8'h0F; tc[0] = 8'hFF; td[0] = 8'h3C;
        ta[1] = 8'h00; tb[1] = 8'h00; tc[1] = 8'h00; td[1] = 8'h00;
        ta[2] = 8'h5A; tb[2] = 8'hA5; tc[2] = 8'h33; td[2] = 8'hCC;
        i = 0;
        repeat (3) begin
            step(1'b1, ta[i], tb[i], tc[i], td[i], 1'b0, 1'b0, 5'h00);
            if (last_acc) i++;
        end
        chk("t4_accepted", i, 2);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_y_held", y, 8'hC3);
        for (int cyc = 0; cyc < 20 && (i < 3 || exp_q.size() > 0); cyc++) begin
            idx = (i < 3) ? i : 0;
            step(i < 3, ta[idx], tb[idx], tc[idx], td[idx], 1'b1, 1'b0, 5'h00);
            if (last_acc) i++;
        end
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_out_count", out_count, 3);

        // Stream with out_ready toggling every cycle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sa[k] = 8'($urandom); sb[k] = 8'($urandom);
            sc[k] = 8'($urandom); sd[k] = 8'($urandom);
        end
        i = 0;
        for (int cyc = 0; cyc < 200 && (i < 10 || exp_q.size() > 0); cyc++) begin
            idx = (i < 10) ? i : 0;
            step(i < 10, sa[idx], sb[idx], sc[idx], sd[idx], (cyc % 2) == 1, 1'b0, 5'h00);
            if (last_acc) i++;
        end
        chk("t5_sent", i, 10);
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_out_count", out_count, 10);

        // Reset with two beats in flight and a non-default mask.
        step(1'b1, 8'hF0, 8'h0F, 8'hFF, 8'h3C, 1'b0, 1'b1, 5'h00);
        step(1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b0, 5'h00);
        chk("t6_in_flight", out_valid, 1);
`ifdef NOT_BUBBLE_PIPE_PARITY_EN
        chk("t6_y_par_c3", y_par, 0);
        chk("t6_par_err", par_err, 0);
`endif
        do_reset();
        idle(1'b1);
        chk("t6_after_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
